pma_region_scanner: RTL and testbench

- Sequential physical-memory-attribute classifier. It reads the region rule tables carried in the core configuration: NonIdempotent, ExecuteRegion and CachedRegion base/length.
- Returns cacheable / executable / non-idempotent flags for a physical address.
- Walks one rule index per cycle instead of using parallel comparators. Intended for FPGA-oriented builds (FpgaEn) and PMA lookups that are not timing-critical, such as page-table-walker and debug accesses.
- Sits beside the MMU/load-store path and uses a valid/ready request/response handshake.

---
 rtl/pma_region_scanner_pkg.sv | 67 ++++++
 rtl/pma_rule_match.sv | 33 +++
 rtl/pma_region_scanner.sv | 103 ++++++++++
 tb/tb_pma_region_scanner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pma_region_scanner_pkg.sv
// ============================================================================
//  Module  : pma_region_scanner_pkg
//  Brief   : Configuration type, flag struct and rule helpers for the PMA scanner.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package pma_region_scanner_pkg;

    typedef struct packed {
        int unsigned   PLEN;
        int unsigned   NrNonIdempotentRules;
        logic [1023:0] NonIdempotentAddrBase;
        logic [1023:0] NonIdempotentLength;
        int unsigned   NrExecuteRegionRules;
        logic [1023:0] ExecuteRegionAddrBase;
        logic [1023:0] ExecuteRegionLength;
        int unsigned   NrCachedRegionRules;
        logic [1023:0] CachedRegionAddrBase;
        logic [1023:0] CachedRegionLength;
    } cva6_cfg_t;

    typedef struct packed {
        logic cacheable;
        logic executable;
        logic nonidempotent;
    } pma_flags_t;

    // A 1024-bit table holds at most 16 rules of 64 bits each.
    localparam int unsigned c_IDX_W = 4;

    localparam cva6_cfg_t c_PMA_DEFAULT_CFG = '{
        PLEN:                  56,
        NrNonIdempotentRules:  2,
        NonIdempotentAddrBase: 1024'({64'h8000_0000, 64'h0}),
        NonIdempotentLength:   '0,
        NrExecuteRegionRules:  3,
        ExecuteRegionAddrBase: 1024'({64'h8000_0000, 64'h1_0000, 64'h0}),
        ExecuteRegionLength:   1024'({64'h4000_0000, 64'h1_0000, 64'h1000}),
        NrCachedRegionRules:   1,
        CachedRegionAddrBase:  1024'(64'h8000_0000),
        CachedRegionLength:    1024'(64'h4000_0000)
    };

    function automatic logic [63:0] get_rule(input logic [1023:0] vec, input logic [c_IDX_W-1:0] idx);
        return vec[{idx, 6'b0} +: 64];
    endfunction

    // The end is formed at 65 bits so a region touching the top of memory never wraps to 0.
    function automatic logic range_hit(input logic [63:0] addr, input logic [63:0] base, input logic [63:0] len);
        logic [64:0] w_end;
        w_end = {1'b0, base} + {1'b0, len};
        return (len != '0) && ({1'b0, base} <= {1'b0, addr}) && ({1'b0, addr} < w_end);
    endfunction

    function automatic int unsigned scan_len(input cva6_cfg_t cfg);
        int unsigned n;
        n = 1;
        if (cfg.NrNonIdempotentRules > n) n = cfg.NrNonIdempotentRules;
        if (cfg.NrExecuteRegionRules > n) n = cfg.NrExecuteRegionRules;
        if (cfg.NrCachedRegionRules > n)  n = cfg.NrCachedRegionRules;
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pma_rule_match.sv
// ============================================================================
//  Module  : pma_rule_match
//  Brief   : Combinational match of one rule index across all three PMA tables.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module pma_rule_match
    import pma_region_scanner_pkg::*;
#(
    parameter cva6_cfg_t CVA6_CFG = c_PMA_DEFAULT_CFG
) (
    input  logic [c_IDX_W-1:0] idx,
    input  logic [63:0]        addr,
    output pma_flags_t         hit
);

    // Indices beyond a table's rule count contribute nothing for that table.
    assign hit.nonidempotent = (32'(idx) < CVA6_CFG.NrNonIdempotentRules) &&
        range_hit(addr, get_rule(CVA6_CFG.NonIdempotentAddrBase, idx),
                  get_rule(CVA6_CFG.NonIdempotentLength, idx));

    assign hit.executable = (32'(idx) < CVA6_CFG.NrExecuteRegionRules) &&
        range_hit(addr, get_rule(CVA6_CFG.ExecuteRegionAddrBase, idx),
                  get_rule(CVA6_CFG.ExecuteRegionLength, idx));

    assign hit.cacheable = (32'(idx) < CVA6_CFG.NrCachedRegionRules) &&
        range_hit(addr, get_rule(CVA6_CFG.CachedRegionAddrBase, idx),
                  get_rule(CVA6_CFG.CachedRegionLength, idx));

endmodule

`default_nettype wire

// File: rtl/pma_region_scanner.sv
// ============================================================================
//  Module  : pma_region_scanner
//  Brief   : Sequential PMA classifier walking one rule index per cycle.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module pma_region_scanner
    import pma_region_scanner_pkg::*;
#(
    parameter cva6_cfg_t   CVA6_CFG = c_PMA_DEFAULT_CFG,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [CVA6_CFG.PLEN-1:0] req_addr_i,
    input  logic [ID_WIDTH-1:0]      req_id_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_WIDTH-1:0]      rsp_id_o,
    output logic                     rsp_cacheable_o,
    output logic                     rsp_executable_o,
    output logic                     rsp_nonidempotent_o,
    output logic                     busy_o
);

    localparam int unsigned        c_N_SCAN   = scan_len(CVA6_CFG);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N_SCAN - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]               r_state;
    logic [c_IDX_W-1:0]       r_idx;
    logic [CVA6_CFG.PLEN-1:0] r_addr;
    logic [ID_WIDTH-1:0]      r_id;
    pma_flags_t               r_flags;
    pma_flags_t               w_hit;
    logic                     w_accept;

    pma_rule_match #(
        .CVA6_CFG (CVA6_CFG)
    ) u_rule_match (
        .idx  (r_idx),
        .addr (64'(r_addr)),
        .hit  (w_hit)
    );

    // Ready passes straight through in RESP so a consumed response can overlap the next accept.
    assign req_ready_o = !flush_i &&
                         ((r_state == c_ST_IDLE) || ((r_state == c_ST_RESP) && rsp_ready_i));
    assign w_accept    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_flags <= '0;
        end else if (flush_i) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_RESP: begin
                    if (w_accept) begin
                        r_state <= c_ST_SCAN;
                        r_addr  <= req_addr_i;
                        r_id    <= req_id_i;
                        r_flags <= '0;
                        r_idx   <= '0;
                    end else if ((r_state == c_ST_RESP) && rsp_ready_i) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_SCAN: begin
                    r_flags <= r_flags | w_hit;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_o         = (r_state == c_ST_RESP);
    assign busy_o              = (r_state != c_ST_IDLE);
    assign rsp_id_o            = r_id;
    assign rsp_cacheable_o     = r_flags.cacheable;
    assign rsp_executable_o    = r_flags.executable;
    assign rsp_nonidempotent_o = r_flags.nonidempotent;

endmodule

`default_nettype wire

// File: tb/tb_pma_region_scanner.sv
// ============================================================================
//  Module  : tb_pma_region_scanner
//  Brief   : Self-checking bench for the sequential PMA scanner.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pma_region_scanner;
    import pma_region_scanner_pkg::*;

    // Executable table is populated but has a zero rule count, so it must never hit.
    localparam cva6_cfg_t c_WRAP_CFG = '{
        PLEN:                  64,
        NrNonIdempotentRules:  1,
        NonIdempotentAddrBase: 1024'(64'hFFFF_FFFF_FFFF_F000),
        NonIdempotentLength:   1024'(64'h2000),
        NrExecuteRegionRules:  0,
        ExecuteRegionAddrBase: 1024'(64'h0),
        ExecuteRegionLength:   1024'(64'hFFFF_FFFF_FFFF_FFFF),
        NrCachedRegionRules:   1,
        CachedRegionAddrBase:  1024'(64'hFFFF_FFFF_FFFF_F000),
        CachedRegionLength:    1024'(64'h2000)
    };

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a, busy_a;
    logic [55:0] addr_a;
    logic [3:0]  id_a, rsp_id_a;
    logic        c_a, e_a, n_a;
    logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, busy_b;
    logic [63:0] addr_b;
    logic [3:0]  id_b, rsp_id_b;
    logic        c_b, e_b, n_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pma_region_scanner #(.ID_WIDTH(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_addr_i(addr_a), .req_id_i(id_a),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_id_o(rsp_id_a),
        .rsp_cacheable_o(c_a), .rsp_executable_o(e_a), .rsp_nonidempotent_o(n_a), .busy_o(busy_a)
    );

    pma_region_scanner #(.CVA6_CFG(c_WRAP_CFG), .ID_WIDTH(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_addr_i(addr_b), .req_id_i(id_b),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_id_o(rsp_id_b),
        .rsp_cacheable_o(c_b), .rsp_executable_o(e_b), .rsp_nonidempotent_o(n_b), .busy_o(busy_b)
    );

    // Reference model: plain list of regions per table, end-exclusive, no overflow possible.
    typedef struct { longint unsigned base; longint unsigned len; } rule_t;
    rule_t ex_a[$], ca_a[$], ni_a[$], ex_b[$], ca_b[$], ni_b[$];

    function automatic bit hits(input rule_t tbl[$], input longint unsigned addr);
        foreach (tbl[i])
            if (tbl[i].len != 0 && addr >= tbl[i].base && (addr - tbl[i].base) < tbl[i].len) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] model(input bit sel, input longint unsigned addr);
        longint unsigned a56;
        a56 = addr & 64'h00FF_FFFF_FFFF_FFFF;
        if (sel) return {hits(ca_b, addr), hits(ex_b, addr), hits(ni_b, addr)};
        return {hits(ca_a, a56), hits(ex_a, a56), hits(ni_a, a56)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input bit sel, input logic [63:0] addr, input logic [3:0] id, input string name);
        int n;
        @(negedge clk);
        if (sel) begin req_valid_b = 1'b1; addr_b = addr;        id_b = id; end
        else     begin req_valid_a = 1'b1; addr_a = addr[55:0];  id_a = id; end
        #1;
        n = 0;
        while (!(sel ? req_ready_b : req_ready_a) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check({name, "_accept"}, 64'(sel ? req_ready_b : req_ready_a), 64'd1);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    task automatic wait_rsp(input bit sel, input int exp_lat, input string name);
        int lat;
        lat = 1;
        while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 50) begin
            @(negedge clk); lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_rsp(input bit sel, input logic [2:0] exp, input logic [3:0] id, input string name);
        check({name, "_flags"}, 64'(sel ? {c_b, e_b, n_b} : {c_a, e_a, n_a}), 64'(exp));
        check({name, "_id"}, 64'(sel ? rsp_id_b : rsp_id_a), 64'(id));
    endtask

    task automatic ack();
        rsp_ready_a = 1'b1;
        rsp_ready_b = 1'b1;
        @(negedge clk);
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
    endtask

    task automatic lookup(input bit sel, input logic [63:0] addr, input logic [3:0] id,
                          input logic [2:0] exp, input string name);
        issue(sel, addr, id, name);
        wait_rsp(sel, sel ? 2 : 4, name);
        check_rsp(sel, exp, id, name);
        ack();
    endtask

    typedef struct { logic [63:0] addr; logic [3:0] id; logic [2:0] exp; bit sel; } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        req_valid_a = 1'b0; rsp_ready_a = 1'b0; addr_a = '0; id_a = '0;
        req_valid_b = 1'b0; rsp_ready_b = 1'b0; addr_b = '0; id_b = '0;

        ex_a.push_back('{base: 64'h0,         len: 64'h1000});
        ex_a.push_back('{base: 64'h1_0000,    len: 64'h1_0000});
        ex_a.push_back('{base: 64'h8000_0000, len: 64'h4000_0000});
        ca_a.push_back('{base: 64'h8000_0000, len: 64'h4000_0000});
        ni_a.push_back('{base: 64'h0,         len: 64'h0});
        ni_a.push_back('{base: 64'h8000_0000, len: 64'h0});
        ca_b.push_back('{base: 64'hFFFF_FFFF_FFFF_F000, len: 64'h2000});
        ni_b.push_back('{base: 64'hFFFF_FFFF_FFFF_F000, len: 64'h2000});

        // {c, e, n}
        tbl[0] = '{addr: 64'h8000_0000,           id: 4'd1, exp: 3'b110, sel: 1'b0};
        tbl[1] = '{addr: 64'h0FFF,                id: 4'd2, exp: 3'b010, sel: 1'b0};
        tbl[2] = '{addr: 64'h1000,                id: 4'd3, exp: 3'b000, sel: 1'b0};
        tbl[3] = '{addr: 64'hBFFF_FFFF,           id: 4'd4, exp: 3'b110, sel: 1'b0};
        tbl[4] = '{addr: 64'hC000_0000,           id: 4'd5, exp: 3'b000, sel: 1'b0};
        tbl[5] = '{addr: 64'h0,                   id: 4'd6, exp: 3'b010, sel: 1'b0};
        tbl[6] = '{addr: 64'hFFFF_FFFF_FFFF_FFF0, id: 4'd7, exp: 3'b101, sel: 1'b1};
        tbl[7] = '{addr: 64'h10,                  id: 4'd8, exp: 3'b000, sel: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_a", {rsp_valid_a, c_a, e_a, n_a, rsp_id_a, busy_a, req_ready_a}, {1'b0, 3'b000, 4'd0, 1'b0, 1'b1});
        check("reset_b", {rsp_valid_b, c_b, e_b, n_b, rsp_id_b, busy_b, req_ready_b}, {1'b0, 3'b000, 4'd0, 1'b0, 1'b1});
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            lookup(tbl[i].sel, tbl[i].addr, tbl[i].id, tbl[i].exp, $sformatf("vec%0d", i));

        // Randomised addresses, biased towards region edges.
        for (int i = 0; i < 30; i++) begin
            longint unsigned edges[6] = '{64'h0, 64'h1000, 64'h1_0000, 64'h2_0000, 64'h8000_0000, 64'hC000_0000};
            longint unsigned a;
            if ($urandom_range(0, 1) == 0) a = {31'd0, 1'($urandom), $urandom};
            else a = (edges[$urandom_range(0, 5)] + 64'($urandom_range(0, 4)) - 64'd2) & 64'h00FF_FFFF_FFFF_FFFF;
            lookup(1'b0, a, 4'(i), model(1'b0, a), $sformatf("rand_a%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            longint unsigned a;
            a = (i % 2 == 0) ? 64'hFFFF_FFFF_FFFF_EFF0 + 64'($urandom_range(0, 32)) + 64'($urandom_range(0, 1)) * 64'h1000
                             : 64'($urandom_range(0, 8191));
            lookup(1'b1, a, 4'(i), model(1'b1, a), $sformatf("rand_b%0d", i));
        end

        // Backpressure with a second request waiting.
        issue(1'b0, 64'h8000_0000, 4'd1, "bp1");
        wait_rsp(1'b0, 4, "bp1");
        req_valid_a = 1'b1; addr_a = 56'h1000; id_a = 4'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold%0d", i), {rsp_valid_a, c_a, e_a, n_a, rsp_id_a, req_ready_a},
                  {1'b1, 3'b110, 4'd1, 1'b0});
            @(negedge clk);
        end
        rsp_ready_a = 1'b1;
        #1;
        check("bp_pass_ready", 64'(req_ready_a), 64'd1);
        @(negedge clk);
        rsp_ready_a = 1'b0; req_valid_a = 1'b0;
        wait_rsp(1'b0, 4, "bp2");
        check_rsp(1'b0, 3'b000, 4'd2, "bp2");
        ack();

        // Flush in the second scan cycle.
        issue(1'b0, 64'h8000_0000, 4'd3, "fl");
        @(negedge clk);
        flush = 1'b1; req_valid_a = 1'b1; addr_a = 56'h0FFF; id_a = 4'd9;
        #1;
        check("fl_ready_low", {req_ready_a, busy_a}, {1'b0, 1'b1});
        @(negedge clk);
        flush = 1'b0; req_valid_a = 1'b0;
        #1;
        check("fl_idle", {busy_a, req_ready_a, rsp_valid_a}, {1'b0, 1'b1, 1'b0});
        begin
            bit seen;
            seen = 1'b0;
            repeat (6) begin @(negedge clk); seen |= rsp_valid_a | busy_a; end
            check("fl_no_rsp", 64'(seen), 64'd0);
        end
        lookup(1'b0, 64'h0FFF, 4'd5, 3'b010, "fl_after");

        // Reset while a response is pending.
        issue(1'b0, 64'h8000_0000, 4'd6, "rs");
        wait_rsp(1'b0, 4, "rs");
        rst = 1'b1;
        @(negedge clk);
        check("rs_clear", {rsp_valid_a, c_a, e_a, n_a, rsp_id_a, busy_a, req_ready_a}, {1'b0, 3'b000, 4'd0, 1'b0, 1'b1});
        rst = 1'b0;
        lookup(1'b0, 64'hBFFF_FFFF, 4'd7, 3'b110, "rs_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
